microcode_sequencer: RTL and testbench
======================================

Name: microcode_sequencer

Overview:
- Upstream neighbour of the Control decoder.
- Owns the T-state counter that steps through each instruction's microprogram.
- Hard-wires the two fetch microinstructions. Addresses the external microcode ROM for all later steps.
- Presents the resulting 16-bit microinstruction to Control. Control's RT (reset T-state) signal feeds back to end each instruction early.

Parameters:
- NSTEPS, 8: T-states per instruction. Must be a power of two; the T width is log2(NSTEPS).
- OPW, 8: opcode width, taken from the IR high byte.
- FETCH0, 16'h8020: T0 microinstruction. Encodes PC out (bus_out=0) and address in (bus_in=1), with the ALU not driving (bit15=1).
- FETCH1, 16'hB440: T1 microinstruction. Encodes memory out (bus_out=3), IR in (bus_in=2) and P+ (bit10).

Ports:
- clk  input  1  system clock; rising-edge active.
- reset_bar  input  1  asynchronous, active-low reset.
- opcode  input  OPW  IR high byte; valid from T2 onward.
- RT  input  1  reset-T request, decoded by Control from the current uinstr.
- hold  input  1  freezes the sequencer. Used for single-step and slow-device wait.
- rom_data  input  16  microcode ROM read data; combinational, async read.
- rom_addr  output  OPW+3  microcode ROM address, equal to {opcode, T}.
- uinstr  output  16  microinstruction delivered to Control.
- T  output  3  current T-state.
- fetch  output  1  high while T<2.
- instr_start  output  1  one-cycle pulse on the clock edge that enters T0 from a running instruction.

Behaviour:
- Reset:
  - reset_bar low clears T to 0 immediately, without waiting for clk.
  - instr_start is forced to 0.
  - Outputs follow combinationally: uinstr=FETCH0, fetch=1, rom_addr={opcode,3'd0}.
  - Reset mid-instruction discards the remainder of the microprogram. No partial state survives.
- T counter, updated on each rising clk while reset_bar is high:
  - hold=1: T holds; instr_start=0.
  - else if RT=1 or T==NSTEPS-1: T becomes 0 and instr_start=1 for the following cycle.
  - else: T becomes T+1 and instr_start=0.
- Precedence: hold wins over RT and over wrap. RT asserted together with hold is ignored; if RT is still decoded when hold falls, the return takes effect then.
- Wrap: from T=7 without RT the counter returns to 0, which is a normal instruction boundary.
- uinstr mux, purely combinational from T and rom_data with no extra latency:
  - T=0: uinstr=FETCH0.
  - T=1: uinstr=FETCH1.
  - T>=2: uinstr=rom_data.
- rom_addr is always driven as {opcode, T}. ROM words at T=0 and T=1 are never consumed. ROM read latency must fit within one cycle.
- RT during fetch: the fixed fetch words have RT=0, so RT is not expected at T0 or T1. If asserted externally, it is still honoured: T returns to 0 and instr_start pulses.
- Width: the T counter is exactly 3 bits with no carry out. opcode is passed through unregistered; IR owns the latching.

Test Plan:
- Reset while T=5, mid-cycle, asynchronously → T=0 and uinstr=16'h8020 before the next clk edge; instr_start=0.
- Release reset, opcode=8'h3A, rom_data=16'h1234, no RT, hold=0, 8 clocks:
  - T sequence 0,1,...,7,0.
  - uinstr sequence 8020, B440, then 1234 ×6, then 8020.
  - rom_addr at T=2 is 11'h1D2.
  - instr_start pulses once, on the cycle after T=7.
- RT asserted at T=3 → next T=0, instr_start=1 for exactly one cycle, uinstr=8020.
- hold=1 for 4 cycles at T=2 with RT=1 → T stays 2 and instr_start stays 0. After hold falls with RT still 1, the next edge sets T=0.
- hold=1 at T=0 for 3 cycles → uinstr remains 8020 and fetch=1 throughout; resumes to T=1 when hold falls.
- Sweep opcode 8'h00 and 8'hFF at T=6 → rom_addr is 11'h006 and 11'h7FE respectively.

Source files
------------

// File: rtl/microcode_sequencer.sv
// ============================================================================
// microcode_sequencer : T-state counter, hard-wired fetch words and ROM addressing
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module microcode_sequencer #(
  parameter int          NSTEPS = 8,
  parameter int          OPW    = 8,
  parameter logic [15:0] FETCH0 = 16'h8020,
  parameter logic [15:0] FETCH1 = 16'hB440,
  localparam int         TW     = $clog2(NSTEPS)
) (
  input  logic              clk,
  input  logic              reset_bar,
  input  logic [OPW-1:0]    opcode,
  input  logic              RT,
  input  logic              hold,
  input  logic [15:0]       rom_data,
  output logic [OPW+TW-1:0] rom_addr,
  output logic [15:0]       uinstr,
  output logic [TW-1:0]     T,
  output logic              fetch,
  output logic              instr_start
);

  localparam logic [TW-1:0] T_LAST = TW'(NSTEPS - 1);

  // hold has priority over both RT and the natural wrap
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      T           <= '0;
      instr_start <= 1'b0;
    end else if (hold) begin
      instr_start <= 1'b0;
    end else if (RT || (T == T_LAST)) begin
      T           <= '0;
      instr_start <= 1'b1;
    end else begin
      T           <= T + TW'(1);
      instr_start <= 1'b0;
    end
  end

  always_comb begin
    uinstr = rom_data;
    if (T == TW'(0))
      uinstr = FETCH0;
    else if (T == TW'(1))
      uinstr = FETCH1;
  end

  assign fetch    = (T < TW'(2));
  assign rom_addr = {opcode, T};

endmodule

`default_nettype wire

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: directed scenarios plus randomized
// stimulus compared every cycle against a behavioural model.
`timescale 1ns/1ps
`default_nettype none

module tb_microcode_sequencer;

  localparam int NSTEPS = 8;

  logic        clk;
  logic        reset_bar;
  logic [7:0]  opcode;
  logic        RT;
  logic        hold;
  logic [15:0] rom_data;
  logic [10:0] rom_addr;
  logic [15:0] uinstr;
  logic [2:0]  T;
  logic        fetch;
  logic        instr_start;

  microcode_sequencer dut (
    .clk        (clk),
    .reset_bar  (reset_bar),
    .opcode     (opcode),
    .RT         (RT),
    .hold       (hold),
    .rom_data   (rom_data),
    .rom_addr   (rom_addr),
    .uinstr     (uinstr),
    .T          (T),
    .fetch      (fetch),
    .instr_start(instr_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ROM: either a fixed word or a random table indexed by address
  logic [15:0] rom_mem [0:2047];
  logic        rom_fixed_en;
  logic [15:0] rom_fixed;
  assign rom_data = rom_fixed_en ? rom_fixed : rom_mem[rom_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: instruction step counter and boundary pulse
  int m_t     = 0;
  int m_start = 0;

  always @(negedge reset_bar) begin
    m_t     = 0;
    m_start = 0;
  end

  always @(posedge clk) begin
    if (!reset_bar) begin
      m_t     = 0;
      m_start = 0;
    end else if (hold) begin
      m_start = 0;
    end else if (RT || m_t == NSTEPS - 1) begin
      m_t     = 0;
      m_start = 1;
    end else begin
      m_t     = m_t + 1;
      m_start = 0;
    end
    #1;
    begin
      logic [2:0]  et;
      logic [15:0] eu;
      et = 3'(m_t);
      if (m_t == 0)      eu = 16'h8020;
      else if (m_t == 1) eu = 16'hB440;
      else               eu = rom_fixed_en ? rom_fixed : rom_mem[{opcode, et}];
      chk("model_T", 32'(T), 32'(m_t));
      chk("model_uinstr", 32'(uinstr), 32'(eu));
      chk("model_fetch", 32'(fetch), 32'(m_t < 2));
      chk("model_instr_start", 32'(instr_start), 32'(m_start));
      chk("model_rom_addr", 32'(rom_addr), 32'({opcode, et}));
    end
  end

  task automatic wait_t(input logic [2:0] k);
    int n;
    n = 0;
    while (T !== k && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("wait_for_T", 32'(T), 32'(k));
  endtask

  initial begin
    logic [2:0]  exp_t;
    logic [15:0] exp_u;
    for (int i = 0; i < 2048; i++) rom_mem[i] = 16'($urandom);
    reset_bar    = 1'b0;
    hold         = 1'b0;
    RT           = 1'b0;
    opcode       = 8'h3A;
    rom_fixed_en = 1'b1;
    rom_fixed    = 16'h1234;

    repeat (2) @(negedge clk);
    chk("reset_T", 32'(T), 32'h0);
    chk("reset_uinstr", 32'(uinstr), 32'h8020);
    chk("reset_fetch", 32'(fetch), 32'h1);
    chk("reset_instr_start", 32'(instr_start), 32'h0);
    chk("reset_rom_addr", 32'(rom_addr), 32'h1D0);

    // Full instruction with no RT: 0..7 then wrap
    reset_bar = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      exp_t = 3'(i % 8);
      exp_u = (i == 0 || i == 8) ? 16'h8020 : (i == 1) ? 16'hB440 : 16'h1234;
      chk("seq_T", 32'(T), 32'(exp_t));
      chk("seq_uinstr", 32'(uinstr), 32'(exp_u));
      chk("seq_instr_start", 32'(instr_start), 32'(i == 8));
      if (i == 2) chk("seq_rom_addr_T2", 32'(rom_addr), 32'h1D2);
      @(negedge clk);
    end

    // Early return via RT at T=3
    wait_t(3'd3);
    RT = 1'b1;
    @(negedge clk);
    RT = 1'b0;
    chk("rt_T", 32'(T), 32'h0);
    chk("rt_instr_start", 32'(instr_start), 32'h1);
    chk("rt_uinstr", 32'(uinstr), 32'h8020);
    @(negedge clk);
    chk("rt_pulse_once", 32'(instr_start), 32'h0);
    chk("rt_next_T", 32'(T), 32'h1);

    // hold beats RT; RT acts once hold drops
    @(negedge clk);
    hold = 1'b1;
    RT   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_rt_T", 32'(T), 32'h2);
      chk("hold_rt_instr_start", 32'(instr_start), 32'h0);
    end
    hold = 1'b0;
    @(negedge clk);
    RT = 1'b0;
    chk("hold_release_T", 32'(T), 32'h0);
    chk("hold_release_instr_start", 32'(instr_start), 32'h1);

    // hold during fetch
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_fetch_uinstr", 32'(uinstr), 32'h8020);
      chk("hold_fetch_fetch", 32'(fetch), 32'h1);
    end
    hold = 1'b0;
    @(negedge clk);
    chk("hold_fetch_resume_T", 32'(T), 32'h1);

    // Opcode extremes at T=6
    wait_t(3'd6);
    opcode = 8'h00;
    #1 chk("sweep_rom_addr_00", 32'(rom_addr), 32'h006);
    opcode = 8'hFF;
    #1 chk("sweep_rom_addr_FF", 32'(rom_addr), 32'h7FE);
    opcode = 8'h3A;

    // Asynchronous reset in the middle of a T=5 cycle
    wait_t(3'd5);
    #2 reset_bar = 1'b0;
    #1;
    chk("async_reset_T", 32'(T), 32'h0);
    chk("async_reset_uinstr", 32'(uinstr), 32'h8020);
    chk("async_reset_instr_start", 32'(instr_start), 32'h0);
    @(negedge clk);
    reset_bar = 1'b1;

    // Randomized traffic against the model
    rom_fixed_en = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      reset_bar = ($urandom_range(0, 79) != 0);
      hold      = ($urandom_range(0, 4) == 0);
      RT        = ($urandom_range(0, 6) == 0);
      opcode    = 8'($urandom);
    end
    reset_bar = 1'b1;
    hold      = 1'b0;
    RT        = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
